// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
package bcd_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned BCD_ADJ = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: binary add, then +6 correction when the sum exceeds 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] s_bin;

  // Binary sum and decimal correction
  always_comb begin
    s_bin = (BCD_W+1)'(a) + (BCD_W+1)'(b) + (BCD_W+1)'(ci);
    s     = s_bin[BCD_W-1:0];
    co    = 1'b0;
    if (s_bin > (BCD_W+1)'(BCD_MAX)) begin
      s  = BCD_W'(s_bin + (BCD_W+1)'(BCD_ADJ));
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: one decimal digit per clock through a
// single shared digit adder. Optional operand validation: BCD_ERR_CHECK_EN.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W     = BCD_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           state, state_nx;
  logic [W-1:0]     a_q, b_q, sum_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [IDX_W-1:0] idx_q;
  logic [BCD_W-1:0] dig_a, dig_b, dig_s;
  logic             dig_co;
  logic             last_c;

`ifdef BCD_ERR_CHECK_EN
  logic err_q;
  logic bad_c;

  // Flag any operand digit above 9 at the moment start is sampled
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) bad_c = 1'b1;
      if (b[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) bad_c = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dig_a  = a_q[idx_q*BCD_W +: BCD_W];
  assign dig_b  = b_q[idx_q*BCD_W +: BCD_W];
  assign last_c = (idx_q == IDX_W'(DIGITS - 1));

  bcd_digit_add u_digit (
    .a  (dig_a),
    .b  (dig_b),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef BCD_ERR_CHECK_EN
          state_nx = bad_c ? DONE : RUN;
`else
          state_nx = RUN;
`endif
        end
      end
      RUN:     if (last_c) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, digit-serial datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      busy_q <= (state_nx == RUN);
      done_q <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef BCD_ERR_CHECK_EN
            err_q   <= bad_c;
`endif
          end
        end
        RUN: begin
          sum_q[idx_q*BCD_W +: BCD_W] <= dig_s;
          carry_q <= dig_co;
          idx_q   <= idx_q + 1'b1;
          if (last_c) cout_q <= dig_co;
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=4), optional BCD_ERR_CHECK_EN.
module tb_bcd_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int vec  = 0;
  int miss = 0;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an addition in cycle 0, check busy/done every cycle up to the
  // expected done cycle, the result there, and that it holds one cycle later
  task automatic op(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                    input logic ci, input int lat, input logic [15:0] es,
                    input logic ec, input logic ee);
    start = 1'b1; a = aa; b = bb; cin = ci;
    step();
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = ~ci;
    for (int k = 1; k <= lat; k++) begin
      chk({tag, ".busy"}, 32'(busy), 32'(k < lat));
      chk({tag, ".done"}, 32'(done), 32'(k == lat));
      if (k == lat) begin
        chk({tag, ".sum"},  32'(sum),  32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".err"},  32'(err),  32'(ee));
      end else begin
        step();
      end
    end
    step();
    chk({tag, ".done_drop"}, 32'(done), 32'(0));
    chk({tag, ".sum_hold"},  32'(sum),  32'(es));
    chk({tag, ".cout_hold"}, 32'(cout), 32'(ec));
    chk({tag, ".err_hold"},  32'(err),  32'(ee));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
    step();
    step();
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    chk("rst.sum",  32'(sum),  32'(0));
    chk("rst.cout", 32'(cout), 32'(0));
    chk("rst.err",  32'(err),  32'(0));
    rst = 1'b0;
    step();

    op("add1234", 16'h1234, 16'h5678, 1'b0, 5, 16'h6912, 1'b0, 1'b0);
    op("wrap9999", 16'h9999, 16'h0001, 1'b0, 5, 16'h0000, 1'b1, 1'b0);
    op("max9999", 16'h9999, 16'h9999, 1'b1, 5, 16'h9999, 1'b1, 1'b0);
    op("cin_only", 16'h0000, 16'h0000, 1'b1, 5, 16'h0001, 1'b0, 1'b0);

    // start re-pulsed with new operands in cycle 2 must be ignored
    start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b1;
    step();
    start = 1'b0;
    chk("repulse.busy3", 32'(busy), 32'(1));
    step();
    step();
    chk("repulse.done", 32'(done), 32'(1));
    chk("repulse.sum",  32'(sum),  32'(16'h6912));
    chk("repulse.cout", 32'(cout), 32'(0));
    step();
    chk("repulse.done_drop", 32'(done), 32'(0));

    // rst during cycle 3 discards the operation without a done pulse
    start = 1'b1; a = 16'h4321; b = 16'h1111; cin = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.busy", 32'(busy), 32'(0));
    chk("midrst.done", 32'(done), 32'(0));
    chk("midrst.sum",  32'(sum),  32'(0));
    chk("midrst.cout", 32'(cout), 32'(0));
    chk("midrst.err",  32'(err),  32'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("midrst.no_done", 32'(done), 32'(0));
    end
    op("after_rst", 16'h0456, 16'h0789, 1'b0, 5, 16'h1245, 1'b0, 1'b0);

`ifdef BCD_ERR_CHECK_EN
    op("bad_digit", 16'h12A4, 16'h0000, 1'b0, 1, 16'h0000, 1'b0, 1'b1);
    op("err_clear", 16'h0005, 16'h0005, 1'b0, 5, 16'h0010, 1'b0, 1'b0);
`else
    // A in digit 1: 10 -> (10+6) mod 16 = 0 with carry, giving 1304
    op("bad_digit", 16'h12A4, 16'h0000, 1'b0, 5, 16'h1304, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
